// File: rtl/y86_fetch_seq_if.sv
// y86_fetch_seq_if: byte-wide instruction memory port of the Y86-64 fetch
// sequencer. The sequencer is the master (issues one read strobe at a time);
// the instruction memory is the slave and answers with rdata/err on rvalid.
interface y86_fetch_seq_if;
  logic        mem_rd;
  logic [63:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        mem_rvalid;
  logic        mem_err;

  modport master (
    output mem_rd,
    output mem_addr,
    input  mem_rdata,
    input  mem_rvalid,
    input  mem_err
  );

  modport slave (
    input  mem_rd,
    input  mem_addr,
    output mem_rdata,
    output mem_rvalid,
    output mem_err
  );
endinterface

// File: rtl/y86_fetch_seq.sv
// y86_fetch_seq: multi-cycle Y86-64 instruction fetch sequencer.
// Reads an instruction one byte at a time, sizes it from icode, assembles
// icode/ifun/rA/rB/valC (little-endian) and valP, and hands the result to
// the datapath on an inst_valid/inst_ready handshake.
// Optional feature: define FETCH_BOUND_CHECK_EN to fault any byte address
// >= IMEM_BYTES without issuing it to memory.
module y86_fetch_seq #(
  parameter int IMEM_BYTES = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   fetch_req,
  input  logic [63:0]            fetch_pc,
  output logic                   fetch_ready,
  y86_fetch_seq_if.master        mem,
  output logic                   inst_valid,
  input  logic                   inst_ready,
  output logic [3:0]             icode,
  output logic [3:0]             ifun,
  output logic [3:0]             rA,
  output logic [3:0]             rB,
  output logic [63:0]            valC,
  output logic [63:0]            valP,
  output logic                   instr_valid,
  output logic                   imem_error
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state;
  logic [63:0] base;       // address of instruction byte 0
  logic [3:0]  k;          // bytes captured so far
  logic        rd;         // registered read strobe
  logic [63:0] addr;       // registered read address

  logic [3:0]  cur_code;   // icode in force for the byte being captured
  logic [3:0]  cur_len;    // instruction length implied by cur_code
  logic [3:0]  k_next;
  logic [63:0] next_addr;  // base + k_next, wraps modulo 2^64
  logic        has_regs;   // instruction carries a register byte
  logic        valc_hit;   // current byte belongs to valC
  logic [3:0]  valc_idx;   // byte lane of valC for the current byte

  // Instruction length in bytes from icode; unknown codes count as 1 byte.
  function automatic logic [3:0] inst_len(input logic [3:0] code);
    case (code)
      4'h0, 4'h1, 4'h9:       return 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB: return 4'd2;
      4'h7, 4'h8:             return 4'd9;
      4'h3, 4'h4, 4'h5:       return 4'd10;
      default:                return 4'd1;
    endcase
  endfunction

  // Whether a byte address may be sent to instruction memory.
  function automatic logic addr_ok(input logic [63:0] a);
`ifdef FETCH_BOUND_CHECK_EN
    return (a < 64'(IMEM_BYTES));
`else
    // no range limit in this build: every address is treated as in range
    return (a < 64'(IMEM_BYTES)) || 1'b1;
`endif
  endfunction

  assign fetch_ready   = (state == IDLE);
  assign mem.mem_rd    = rd;
  assign mem.mem_addr  = addr;

  // Decode where the incoming byte lands, given the byte index k.
  always_comb begin
    cur_code  = (k == 4'd0) ? mem.mem_rdata[7:4] : icode;
    cur_len   = inst_len(cur_code);
    k_next    = k + 4'd1;
    next_addr = base + {60'd0, k_next};
    has_regs  = (cur_len == 4'd2) || (cur_len == 4'd10);
    if (cur_len == 4'd9) begin
      valc_hit = (k >= 4'd1);
      valc_idx = k - 4'd1;
    end else if (cur_len == 4'd10) begin
      valc_hit = (k >= 4'd2);
      valc_idx = k - 4'd2;
    end else begin
      valc_hit = 1'b0;
      valc_idx = 4'd0;
    end
  end

  // Fetch FSM: request a byte, wait for it, capture it, repeat until done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      base        <= 64'd0;
      k           <= 4'd0;
      rd          <= 1'b0;
      addr        <= 64'd0;
      inst_valid  <= 1'b0;
      icode       <= 4'd0;
      ifun        <= 4'd0;
      rA          <= 4'd0;
      rB          <= 4'd0;
      valC        <= 64'd0;
      valP        <= 64'd0;
      instr_valid <= 1'b0;
      imem_error  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (fetch_req) begin
            base        <= fetch_pc;
            k           <= 4'd0;
            icode       <= 4'd0;
            ifun        <= 4'd0;
            rA          <= 4'd0;
            rB          <= 4'd0;
            valC        <= 64'd0;
            valP        <= fetch_pc;
            instr_valid <= 1'b0;
            imem_error  <= 1'b0;
            addr        <= fetch_pc;
            rd          <= addr_ok(fetch_pc);
            state       <= REQ;
          end
        end
        REQ: begin
          // rd low here means the address was refused before issue
          rd <= 1'b0;
          if (rd) begin
            state <= WAIT;
          end else begin
            imem_error <= 1'b1;
            inst_valid <= 1'b1;
            state      <= DONE;
          end
        end
        WAIT: begin
          if (mem.mem_rvalid) begin
            if (mem.mem_err) begin
              imem_error <= 1'b1;
              inst_valid <= 1'b1;
              state      <= DONE;
            end else begin
              if (k == 4'd0) begin
                icode       <= mem.mem_rdata[7:4];
                ifun        <= mem.mem_rdata[3:0];
                instr_valid <= (mem.mem_rdata[7:4] <= 4'hB);
              end
              if ((k == 4'd1) && has_regs) begin
                rA <= mem.mem_rdata[7:4];
                rB <= mem.mem_rdata[3:0];
              end
              if (valc_hit) begin
                valC <= valC | ({56'd0, mem.mem_rdata} << {valc_idx[2:0], 3'b000});
              end
              k    <= k_next;
              valP <= next_addr;
              if (k_next == cur_len) begin
                inst_valid <= 1'b1;
                state      <= DONE;
              end else begin
                addr  <= next_addr;
                rd    <= addr_ok(next_addr);
                state <= REQ;
              end
            end
          end
        end
        DONE: begin
          if (inst_ready) begin
            inst_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          rd         <= 1'b0;
          inst_valid <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule
